// File: rtl/vga_pkg.sv
// Shared VGA pixel-interface types: default active geometry, the {b,g,r} pixel
// word used by the display controller, and the capture FSM states.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   typedef struct packed {
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
   } bgr_t;

   typedef enum logic [1:0] {
      ST_SEEK   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_ACTIVE = 2'd2
   } vga_state_e;

   // Debug view of the capture block: FSM state plus the registered HS edge.
   typedef struct packed {
      vga_state_e state;
      logic       hs_fall;
   } vga_dbg_t;

endpackage

// File: rtl/vga_timing_meas.sv
// Line/frame measurement for the capture path: active pixel count per line,
// line count per frame, conformance of each frame and the lock counter.
module vga_timing_meas
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic        pixel_i,
   input  logic        line_end_i,
   input  logic        frame_end_i,
   input  logic        frame_clr_i,
   input  logic        blank_low_i,
   output logic [9:0]  row_o,
   output logic [11:0] h_meas_o,
   output logic [9:0]  v_meas_o,
   output logic        frame_done_o,
   output logic        frame_ok_o,
   output logic        locked_o
);

   localparam logic [11:0] H_REQ    = 12'(H_ACTIVE);
   localparam logic [9:0]  V_REQ    = 10'(V_ACTIVE);
   localparam logic [3:0]  LOCK_REQ = 4'(LOCK_FRAMES);

   logic [11:0] h_cnt_q, h_cnt_d;
   logic [9:0]  row_q, row_d;
   logic        line_bad_q, line_bad_d;
   logic [11:0] h_meas_q, h_meas_d;
   logic [9:0]  v_meas_q, v_meas_d;
   logic        done_q, done_d;
   logic        ok_q, ok_d;
   logic [3:0]  lock_cnt_q, lock_cnt_d;
   logic        locked_q, locked_d;
   logic [9:0]  row_le;
   logic        bad_le;

   always_comb begin
      h_cnt_d    = h_cnt_q;
      row_d      = row_q;
      line_bad_d = line_bad_q;
      h_meas_d   = h_meas_q;
      v_meas_d   = v_meas_q;
      done_d     = 1'b0;
      ok_d       = ok_q;
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      row_le     = row_q;
      bad_le     = line_bad_q;

      if (pixel_i && (h_cnt_q != 12'hFFF)) h_cnt_d = h_cnt_q + 12'd1;

      // A line end coinciding with the frame end is folded in first, so the
      // frame verdict below sees the updated row count and line status.
      if (line_end_i) begin
         h_meas_d = h_cnt_q;
         h_cnt_d  = 12'd0;
         if (row_q != 10'h3FF) row_le = row_q + 10'd1;
         bad_le     = line_bad_q | (h_cnt_q != H_REQ);
         row_d      = row_le;
         line_bad_d = bad_le;
      end

      if (frame_end_i) begin
         v_meas_d = row_le;
         done_d   = 1'b1;
         ok_d     = !bad_le && (row_le == V_REQ) && blank_low_i;
      end

      // A partial line cut by VS is dropped from measurement here.
      if (frame_clr_i) begin
         row_d      = 10'd0;
         line_bad_d = 1'b0;
         h_cnt_d    = 12'd0;
      end

      if (done_q) begin
         if (ok_q) begin
            if (lock_cnt_q != 4'hF) lock_cnt_d = lock_cnt_q + 4'd1;
            locked_d = (({1'b0, lock_cnt_q} + 5'd1) >= {1'b0, LOCK_REQ});
         end else begin
            lock_cnt_d = 4'd0;
            locked_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         h_cnt_q    <= '0;
         row_q      <= '0;
         line_bad_q <= 1'b0;
         h_meas_q   <= '0;
         v_meas_q   <= '0;
         done_q     <= 1'b0;
         ok_q       <= 1'b0;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         row_q      <= row_d;
         line_bad_q <= line_bad_d;
         h_meas_q   <= h_meas_d;
         v_meas_q   <= v_meas_d;
         done_q     <= done_d;
         ok_q       <= ok_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

   assign row_o        = row_q;
   assign h_meas_o     = h_meas_q;
   assign v_meas_o     = v_meas_q;
   assign frame_done_o = done_q;
   assign frame_ok_o   = ok_q;
   assign locked_o     = locked_q;

endmodule

// File: rtl/vga_stream_capture.sv
// VGA stream sink: registers the incoming pixel stream, follows frames with a
// SEEK/ARMED/ACTIVE FSM and turns active pixels into frame-RAM writes.
module vga_stream_capture
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int LOCK_FRAMES = 2,
   parameter int ADDR_W      = 19
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_hs,
   input  logic              i_vs,
   input  logic              i_blank_n,
   input  logic [7:0]        i_b,
   input  logic [7:0]        i_g,
   input  logic [7:0]        i_r,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [23:0]       o_wr_data,
   output logic [9:0]        o_row,
   output logic [9:0]        o_col,
   output logic              o_frame_done,
   output logic              o_frame_ok,
   output logic [11:0]       o_h_meas,
   output logic [9:0]        o_v_meas,
   output logic              o_locked,
   output vga_dbg_t          o_dbg
);

   localparam logic [9:0]        H_LIM  = 10'(H_ACTIVE);
   localparam logic [9:0]        V_LIM  = 10'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

   logic        hs_q, vs_q, blank_q;
   logic        hs_prev_q, vs_prev_q, blank_prev_q;
   bgr_t        pix_q;

   vga_state_e        state_q, state_d;
   logic [9:0]        col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] base_q, base_d;

   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   bgr_t              wr_data_q;
   logic [9:0]        wr_row_q, wr_col_q;

   logic       vs_fall, hs_fall, blank_rise, blank_fall;
   logic       frame_end, line_end, pixel, wr_ok;
   logic [9:0] meas_row;

   // Stage 1: every input is registered; edges compare against the prior sample.
   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
         blank_q      <= 1'b0;
         pix_q        <= '0;
         hs_prev_q    <= 1'b1;
         vs_prev_q    <= 1'b1;
         blank_prev_q <= 1'b0;
      end else begin
         hs_q         <= i_hs;
         vs_q         <= i_vs;
         blank_q      <= i_blank_n;
         pix_q        <= '{b: i_b, g: i_g, r: i_r};
         hs_prev_q    <= hs_q;
         vs_prev_q    <= vs_q;
         blank_prev_q <= blank_q;
      end
   end

   always_comb begin
      vs_fall    = vs_prev_q & ~vs_q;
      hs_fall    = hs_prev_q & ~hs_q;
      blank_rise = ~blank_prev_q & blank_q;
      blank_fall = blank_prev_q & ~blank_q;
      frame_end  = vs_fall && (state_q != ST_SEEK);
      line_end   = blank_fall && (state_q == ST_ACTIVE);
      // VS wins over a pixel in the same cycle: that cycle belongs to no line.
      pixel      = blank_q && !vs_fall &&
                   ((state_q == ST_ACTIVE) || ((state_q == ST_ARMED) && blank_rise));
      wr_ok      = pixel && (col_q < H_LIM) && (meas_row < V_LIM);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SEEK:   if (vs_fall) state_d = ST_ARMED;
         ST_ARMED:  if (!vs_fall && blank_rise) state_d = ST_ACTIVE;
         ST_ACTIVE: if (vs_fall) state_d = ST_ARMED;
         default:   state_d = ST_SEEK;
      endcase
   end

   // Address is kept as line base + column so short lines cannot skew later rows.
   always_comb begin
      col_d  = col_q;
      addr_d = addr_q;
      base_d = base_q;
      if (wr_ok) begin
         col_d  = col_q + 10'd1;
         addr_d = addr_q + ADDR_W'(1);
      end
      if (line_end) begin
         col_d = 10'd0;
         if (meas_row < V_LIM) base_d = base_q + H_STEP;
         addr_d = base_d;
      end
      if (vs_fall) begin
         col_d  = 10'd0;
         addr_d = '0;
         base_d = '0;
      end
   end

   always_ff @(posedge clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= ST_SEEK;
         col_q     <= '0;
         addr_q    <= '0;
         base_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_row_q  <= '0;
         wr_col_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         base_q  <= base_d;
         wr_en_q <= wr_ok;
         if (wr_ok) begin
            wr_addr_q <= addr_q;
            wr_data_q <= pix_q;
            wr_row_q  <= meas_row;
            wr_col_q  <= col_q;
         end
      end
   end

   vga_timing_meas #(
      .H_ACTIVE    (H_ACTIVE),
      .V_ACTIVE    (V_ACTIVE),
      .LOCK_FRAMES (LOCK_FRAMES)
   ) u_meas (
      .clk          (clk),
      .i_rst        (i_rst),
      .pixel_i      (pixel),
      .line_end_i   (line_end),
      .frame_end_i  (frame_end),
      .frame_clr_i  (vs_fall),
      .blank_low_i  (~blank_q),
      .row_o        (meas_row),
      .h_meas_o     (o_h_meas),
      .v_meas_o     (o_v_meas),
      .frame_done_o (o_frame_done),
      .frame_ok_o   (o_frame_ok),
      .locked_o     (o_locked)
   );

   assign o_wr_en       = wr_en_q;
   assign o_wr_addr     = wr_addr_q;
   assign o_wr_data     = wr_data_q;
   assign o_row         = wr_row_q;
   assign o_col         = wr_col_q;
   assign o_dbg.state   = state_q;
   assign o_dbg.hs_fall = hs_fall;

endmodule

// File: tb/tb_vga_stream_capture.sv
// Self-checking bench for vga_stream_capture on an 8x4 geometry: a per-cycle
// expectation queue built from frame/line/pixel bookkeeping, checked 2 cycles later.
module tb_vga_stream_capture;
   import vga_pkg::*;

   localparam int H    = 8;
   localparam int V    = 4;
   localparam int LOCK = 2;
   localparam int AW   = 19;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [23:0]   data;
      logic [9:0]    row;
      logic [9:0]    col;
      logic          fd;
      logic          ok;
      logic [11:0]   h;
      logic [9:0]    v;
      logic          lk;
   } rec_t;

   logic          clk = 1'b0;
   logic          i_rst, i_hs, i_vs, i_blank_n;
   logic [7:0]    i_b, i_g, i_r;
   logic          o_wr_en;
   logic [AW-1:0] o_wr_addr;
   logic [23:0]   o_wr_data;
   logic [9:0]    o_row, o_col;
   logic          o_frame_done, o_frame_ok;
   logic [11:0]   o_h_meas;
   logic [9:0]    o_v_meas;
   logic          o_locked;
   vga_dbg_t      o_dbg;

   vga_stream_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LOCK), .ADDR_W(AW)) dut (
      .clk(clk), .i_rst(i_rst), .i_hs(i_hs), .i_vs(i_vs), .i_blank_n(i_blank_n),
      .i_b(i_b), .i_g(i_g), .i_r(i_r),
      .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
      .o_row(o_row), .o_col(o_col), .o_frame_done(o_frame_done), .o_frame_ok(o_frame_ok),
      .o_h_meas(o_h_meas), .o_v_meas(o_v_meas), .o_locked(o_locked), .o_dbg(o_dbg)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   rec_t exp_q[$];
   rec_t mr;
   logic lk_exp;
   bit   push_en, mon_en, rel_pending, pat_mode;
   int   rel_col;

   // Reference bookkeeping: whether a frame is being followed, current row,
   // pending line end, sticky bad-line flag, last line length, lock state.
   bit m_armed, m_pend_le, m_bad, m_locked;
   int m_row, m_cur_len, m_hlast, m_lock_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, o_wr_en, 0);
      check({tag, "_wr_addr"}, o_wr_addr, 0);
      check({tag, "_wr_data"}, o_wr_data, 0);
      check({tag, "_row"}, o_row, 0);
      check({tag, "_col"}, o_col, 0);
      check({tag, "_frame_done"}, o_frame_done, 0);
      check({tag, "_frame_ok"}, o_frame_ok, 0);
      check({tag, "_h_meas"}, o_h_meas, 0);
      check({tag, "_v_meas"}, o_v_meas, 0);
      check({tag, "_locked"}, o_locked, 0);
      check({tag, "_state"}, 64'(o_dbg.state), 64'(ST_SEEK));
   endtask

   task automatic model_reset();
      m_armed = 0; m_pend_le = 0; m_bad = 0; m_locked = 0;
      m_row = 0; m_cur_len = 0; m_hlast = 0; m_lock_cnt = 0;
      lk_exp = 1'b0;
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (mon_en && exp_q.size() >= 3) begin
         mr = exp_q.pop_front();
         check("locked", o_locked, lk_exp);
         check("wr_en", o_wr_en, mr.wr);
         if (mr.wr) begin
            check("wr_addr", o_wr_addr, mr.addr);
            check("wr_data", o_wr_data, mr.data);
            check("wr_row", o_row, mr.row);
            check("wr_col", o_col, mr.col);
         end
         check("frame_done", o_frame_done, mr.fd);
         if (mr.fd) begin
            check("frame_ok", o_frame_ok, mr.ok);
            check("h_meas", o_h_meas, mr.h);
            check("v_meas", o_v_meas, mr.v);
            lk_exp = mr.lk;
         end
      end
   end

   task automatic cycle(input logic hs, input logic vs, input logic bl,
                        input logic [23:0] px, input rec_t r);
      @(posedge clk);
      #1;
      i_hs = hs; i_vs = vs; i_blank_n = bl;
      {i_b, i_g, i_r} = px;
      if (rel_pending) begin
         i_rst = 1'b1; rel_pending = 0; push_en = 1; mon_en = 1;
      end
      if (push_en) exp_q.push_back(r);
   endtask

   function automatic rec_t frame_end_model(input bit blank_low, input rec_t r_in);
      rec_t r;
      r = r_in;
      if (m_armed) begin
         r.fd = 1'b1;
         r.ok = blank_low && !m_bad && (m_row == V);
         r.h  = 12'(m_hlast);
         r.v  = 10'(m_row);
         if (r.ok) begin
            if (m_lock_cnt < 15) m_lock_cnt++;
            m_locked = (m_lock_cnt >= LOCK);
         end else begin
            m_lock_cnt = 0;
            m_locked = 0;
         end
         r.lk = m_locked;
      end
      m_armed = 1; m_row = 0; m_bad = 0; m_pend_le = 0;
      return r;
   endfunction

   task automatic pixel(input int c);
      rec_t r;
      logic [23:0] px;
      r  = '0;
      px = pat_mode ? {8'h00, 8'(m_row), 8'(c)} : 24'($urandom);
      if (m_armed && c < H && m_row < V) begin
         r.wr = 1'b1; r.addr = AW'(m_row * H + c); r.data = px;
         r.row = 10'(m_row); r.col = 10'(c);
      end
      if (c == rel_col) rel_pending = 1;
      cycle(($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, px, r);
   endtask

   task automatic idle(input logic hs, input logic vs, input bit vs_edge);
      rec_t r;
      r = '0;
      if (m_pend_le) begin
         m_hlast = (m_cur_len > 4095) ? 4095 : m_cur_len;
         if (m_cur_len != H) m_bad = 1;
         if (m_row < 1023) m_row++;
         m_pend_le = 0;
      end
      if (vs_edge) r = frame_end_model(1'b1, r);
      cycle(hs, vs, 1'b0, 24'($urandom), r);
   endtask

   task automatic line(input int len, input int porch);
      for (int c = 0; c < len; c++) pixel(c);
      if (m_armed) begin m_pend_le = 1; m_cur_len = len; end
      for (int p = 0; p < porch; p++) idle((p == 1 || p == 2) ? 1'b0 : 1'b1, 1'b1, 0);
   endtask

   task automatic vsync();
      idle(1'b1, 1'b0, 1);
      idle(1'b1, 1'b0, 0);
      repeat (3) idle(1'b1, 1'b1, 0);
   endtask

   task automatic good_frame();
      for (int l = 0; l < V; l++) line(H, $urandom_range(3, 6));
      vsync();
   endtask

   // VS drops while blank_n is still high: that cycle carries no pixel write.
   task automatic cut_line(input int cut);
      rec_t r;
      for (int c = 0; c < cut; c++) pixel(c);
      r = frame_end_model(1'b0, rec_t'(0));
      cycle(1'b1, 1'b0, 1'b1, 24'($urandom), r);
      cycle(1'b1, 1'b0, 1'b1, 24'($urandom), rec_t'(0));
      cycle(1'b1, 1'b0, 1'b1, 24'($urandom), rec_t'(0));
      idle(1'b1, 1'b0, 0);
      repeat (3) idle(1'b1, 1'b1, 0);
   endtask

   initial begin
      i_rst = 1'b1; i_hs = 1'b1; i_vs = 1'b1; i_blank_n = 1'b0;
      i_b = '0; i_g = '0; i_r = '0;
      push_en = 0; mon_en = 0; rel_pending = 0; rel_col = -1; pat_mode = 1;
      model_reset();
      #1 i_rst = 1'b0;
      #2 check_all_zero("reset");

      // Reset released mid row 2: partial frame is ignored, no frame_done.
      repeat (3) idle(1'b1, 1'b1, 0);
      line(H, 4); line(H, 4);
      rel_col = 3; line(H, 4); rel_col = -1;
      line(H, 4);
      vsync();

      // Nominal frames, {0,row,col} pixels; lock after the second frame_done.
      repeat (3) good_frame();
      check("locked_nominal", o_locked, 1);

      // Overlong last line: 9th pixel dropped, h_meas 9, lock lost then regained.
      line(H, 4); line(H, 4); line(H, 4); line(H + 1, 4);
      vsync();
      check("unlocked_long_line", o_locked, 0);
      repeat (2) good_frame();

      // Five lines: row 4 never written, v_meas 5.
      repeat (5) line(H, 4);
      vsync();
      repeat (2) good_frame();

      // VS at col 3 of row 1, then restart at addr 0.
      line(H, 4); cut_line(3);
      repeat (2) good_frame();

      // Random colours, random line lengths and counts.
      pat_mode = 0;
      repeat (4) begin
         int nl;
         nl = $urandom_range(3, 5);
         for (int l = 0; l < nl; l++) begin
            int len, porch;
            len   = ($urandom_range(0, 2) == 0) ? $urandom_range(6, 10) : H;
            porch = (l == nl - 1 && $urandom_range(0, 1) == 1) ? 0 : $urandom_range(3, 6);
            line(len, porch);
         end
         vsync();
      end
      repeat (2) good_frame();

      // Last line end and VS fall in the same cycle on a conforming frame.
      line(H, 4); line(H, 4); line(H, 4); line(H, 0);
      vsync();
      check("locked_pre_rst", o_locked, 1);

      // Asynchronous reset mid-line while locked.
      for (int c = 0; c < 4; c++) pixel(c);
      @(posedge clk);
      #3;
      i_rst = 1'b0; mon_en = 0; push_en = 0;
      #1 check_all_zero("async_rst");
      model_reset();

      // After release: SEEK until VS, then a clean frame.
      rel_pending = 1;
      repeat (3) idle(1'b1, 1'b1, 0);
      good_frame();
      good_frame();
      repeat (4) idle(1'b1, 1'b1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
